// File: rtl/unpack_pkg.sv
// rtl/unpack_pkg.sv - shared types and sizing helpers for the wide-vector unpacker
package unpack_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Number of DW-bit chunks needed to cover an o_vec-bit vector
    function automatic int nchunk(input int o_vec, input int dw);
        return (o_vec + dw - 1) / dw;
    endfunction

    // Chunk counter width; a single-chunk vector still gets a 1-bit counter
    function automatic int cnt_w(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/vec_unpacker.sv
// rtl/vec_unpacker.sv - captures a wide vector and streams it out LSB chunk first (optional out_par via UNPACK_PARITY_EN)
module vec_unpacker
    import unpack_pkg::*;
#(
    parameter int DW    = 8,
    parameter int O_VEC = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [O_VEC-1:0] vec_in,
    output logic             busy,
    output logic [DW-1:0]    out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
`ifdef UNPACK_PARITY_EN
    ,
    output logic             out_par
`endif
);

    localparam int NCHUNK = nchunk(O_VEC, DW);
    localparam int CW     = cnt_w(NCHUNK);
    localparam int SW     = NCHUNK * DW;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [SW-1:0]   r_shift;
    logic            w_send;
    logic            w_last;

    assign w_send = (r_state == SEND);
    assign w_last = w_send && (r_cnt == CW'(NCHUNK - 1));

    // FSM, chunk counter and shift register; shift register is zeroed whenever
    // the block returns to IDLE so out_data reads 0 while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (clr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ld) begin
                        r_shift <= SW'(vec_in);
                        r_cnt   <= '0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (w_last) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_shift <= '0;
                        end else begin
                            r_shift <= r_shift >> DW;
                            r_cnt   <= r_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_shift <= '0;
                end
            endcase
        end
    end

    assign busy      = w_send;
    assign out_valid = w_send;
    assign out_last  = w_last;
    assign out_data  = r_shift[DW-1:0];

`ifdef UNPACK_PARITY_EN
    // Even parity of the presented chunk; the shift register is zero when idle
    assign out_par = ^r_shift[DW-1:0];
`endif

endmodule

// File: tb/tb_vec_unpacker.sv
// tb/tb_vec_unpacker.sv - directed self-checking bench for vec_unpacker
module tb_vec_unpacker;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        ld;
    logic [20:0] vec_in;
    logic        busy;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
`ifdef UNPACK_PARITY_EN
    logic        out_par;
`endif

    int n_chk;
    int n_pass;

    vec_unpacker #(.DW(8), .O_VEC(21)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .ld        (ld),
        .vec_in    (vec_in),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
`ifdef UNPACK_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_chunk(input string tag, input logic [7:0] d, input logic last);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_busy"},  32'(busy),      32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_last"},  32'(out_last),  32'(last));
`ifdef UNPACK_PARITY_EN
        chk({tag, "_par"},   32'(out_par),   32'(^d));
`endif
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_data"},  32'(out_data),  32'd0);
        chk({tag, "_last"},  32'(out_last),  32'd0);
`ifdef UNPACK_PARITY_EN
        chk({tag, "_par"},   32'(out_par),   32'd0);
`endif
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b1;
        clr       = 1'b0;
        ld        = 1'b0;
        vec_in    = '0;
        out_ready = 1'b0;

        // reset, then idle with no ld
        tick;
        tick;
        chk_idle("reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_idle("idle_noload");
        end

        // basic stream, out_ready held high
        out_ready = 1'b1;
        vec_in    = 21'h1ABCDE;
        ld        = 1'b1;
        tick;
        ld = 1'b0;
        chk_chunk("basic_c0", 8'hDE, 1'b0);
`ifdef UNPACK_PARITY_EN
        chk("par_c0_const", 32'(out_par), 32'd0);
`endif
        tick;
        chk_chunk("basic_c1", 8'hBC, 1'b0);
`ifdef UNPACK_PARITY_EN
        chk("par_c1_const", 32'(out_par), 32'd1);
`endif
        tick;
        chk_chunk("basic_c2", 8'h1A, 1'b1);
`ifdef UNPACK_PARITY_EN
        chk("par_c2_const", 32'(out_par), 32'd1);
`endif
        tick;
        chk_idle("basic_done");

        // backpressure on chunk 1 for 4 cycles
        ld = 1'b1;
        tick;
        ld = 1'b0;
        chk_chunk("bp_c0", 8'hDE, 1'b0);
        tick;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_chunk("bp_hold", 8'hBC, 1'b0);
            tick;
        end
        chk_chunk("bp_hold_end", 8'hBC, 1'b0);
        out_ready = 1'b1;
        tick;
        chk_chunk("bp_c2", 8'h1A, 1'b1);
        tick;
        chk_idle("bp_done");

        // ld while busy is ignored, then clr aborts chunk 1
        ld = 1'b1;
        tick;
        chk_chunk("ign_c0", 8'hDE, 1'b0);
        vec_in = 21'h000055;
        tick;
        ld = 1'b0;
        chk_chunk("ign_c1", 8'hBC, 1'b0);
        clr = 1'b1;
        ld  = 1'b1;
        tick;
        clr = 1'b0;
        ld  = 1'b0;
        chk_idle("clr_abort");
        tick;
        chk_idle("clr_stays_idle");

        // fresh load after abort; ld on the final handshake is ignored
        ld = 1'b1;
        tick;
        ld = 1'b0;
        chk_chunk("fresh_c0", 8'h55, 1'b0);
        tick;
        chk_chunk("fresh_c1", 8'h00, 1'b0);
        tick;
        chk_chunk("fresh_c2", 8'h00, 1'b1);
        vec_in = 21'h1ABCDE;
        ld     = 1'b1;
        tick;
        ld = 1'b0;
        chk_idle("ld_on_last_ignored");

        // asynchronous reset mid-cycle during chunk 0
        ld = 1'b1;
        tick;
        ld = 1'b0;
        chk_chunk("rst_c0", 8'hDE, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("async_rst");
        tick;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_idle("post_rst_idle");
        end
        ld = 1'b1;
        tick;
        ld = 1'b0;
        chk_chunk("post_rst_c0", 8'hDE, 1'b0);
        tick;
        chk_chunk("post_rst_c1", 8'hBC, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vec_unpacker.md
Name: vec_unpacker

Overview:
Reader side of the wide-vector holding registers used in the neural-network datapath. It captures an O_VEC-bit vector on a load pulse and streams it out as DW-bit chunks, LSB chunk first, over a valid/ready handshake. It feeds narrow consumers such as the byte-wide MAC input and debug readout, from a vector produced by a wide weight/output register.

Parameters:
DW, 8, chunk (output) width in bits
O_VEC, 21, input vector width in bits; NCHUNK = ceil(O_VEC/DW), 3 at defaults

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous abort/clear, higher priority than ld and the handshake
ld  input  1  capture vec_in and start streaming; honoured only when busy=0
vec_in  input  O_VEC  vector to unpack
busy  output  1  high from capture until the last chunk is accepted
out_data  output  DW  current chunk
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts the chunk when out_valid=1 at a rising edge
out_last  output  1  high with out_valid on chunk NCHUNK-1

Behaviour:
- Reset: rst=1 asynchronously forces the state to IDLE. All of the following are zero: chunk counter, shift register, busy, out_valid, out_last, out_data.
- FSM states:
  - IDLE: busy=0, out_valid=0.
  - SEND: busy=1, out_valid=1.
- IDLE to SEND: at the edge where ld=1 and clr=0.
  - vec_in is zero-extended to NCHUNK*DW bits and loaded into the shift register.
  - The counter is set to 0.
  - out_valid is high in the cycle after the ld edge, so latency is 1 cycle.
- In SEND:
  - out_data = shift register bits [DW-1:0].
  - out_last = 1 when counter == NCHUNK-1.
- Handshake: a chunk transfers at an edge with out_valid=1 and out_ready=1.
  - If it is not the last chunk: shift right by DW and increment the counter.
  - If it is the last chunk: return to IDLE, and busy/out_valid fall in the next cycle.
- Stall: while out_valid=1 and out_ready=0, out_data, out_last and the counter hold stable.
- Chunk k equals vec[k*DW +: DW]. Bits above O_VEC-1 in the final chunk read as 0 (21-bit default: chunk 2 bits [7:5]=0).
- ld while busy=1 is ignored, and the captured vector is unaffected. ld in the same cycle as the final handshake is also ignored. Back-to-back vectors therefore need one IDLE cycle.
- clr=1 at an edge, in any state: go to IDLE and zero the counter, shift register and outputs. Any pending chunk is dropped. A simultaneous ld is ignored.
- When O_VEC <= DW, NCHUNK=1: the single chunk is presented with out_last=1.
- Counter width is $clog2(NCHUNK), minimum 1. The counter never exceeds NCHUNK-1; there is no wrap.
- Reset asserted mid-stream aborts immediately. After release the block sits in IDLE and needs a new ld.
- out_ready is don't-care while out_valid=0.

Optional Feature:
Macro UNPACK_PARITY_EN.
- Defined: adds output out_par (1 bit), the even parity (XOR-reduce) of out_data. It is valid with out_valid and 0 otherwise, including after reset and clr.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package unpack_pkg holds:
  - the state enum (IDLE, SEND);
  - a function nchunk(o_vec, dw) returning ceil(o_vec/dw);
  - a function cnt_w(n) returning max(1, $clog2(n)).
- No sub-module. The FSM, counter and shift register are small and tightly coupled, so the block stays a single module.

Test Plan:
- Reset then idle: rst pulse → busy=0, out_valid=0, out_data=0, out_last=0; ld not yet asserted → outputs stay 0.
- Basic stream, out_ready=1 constant, vec_in=21'h1ABCDE, ld one cycle:
  - out_data = 8'hDE, 8'hBC, 8'h1A on 3 consecutive cycles, starting 1 cycle after ld;
  - out_last only on 8'h1A;
  - busy low the cycle after.
- Backpressure, same vector, out_ready low for 4 cycles on chunk 1: 8'hBC and out_last=0 held for all 4 cycles; the stream resumes with 8'h1A, no loss or duplication.
- Ignored load and abort:
  - ld with vec_in=21'h000055 while streaming 21'h1ABCDE → stream unchanged.
  - clr during chunk 1 → next cycle out_valid=0, busy=0.
  - A fresh ld of 21'h000055 → 8'h55, 8'h00, 8'h00.
- Mid-stream reset: rst asserted asynchronously mid-cycle during chunk 0 → outputs 0 immediately, no chunks after release until a new ld.
- UNPACK_PARITY_EN build, vec_in=21'h1ABCDE → out_par = 0, 1, 1 for 8'hDE, 8'hBC, 8'h1A; 0 while idle.
